// File: rtl/car_count_display_pkg.sv
// Shared types and 7-segment constants for the car count display.
// Active-low segment order is {g,f,e,d,c,b,a}.
package car_count_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  function automatic logic [6:0] seg_decode(
    input logic [3:0] d
  );
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle,
// 4-digit scratch, result held in bcd until the next run.
module bin2bcd_seq
  import car_count_display_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_W - 1);

  conv_state_t      state;
  conv_state_t      state_nxt;
  logic [BIN_W-1:0] shreg;
  logic [15:0]      scratch;
  logic [15:0]      adj;
  logic [CNT_W-1:0] bitcnt;

  // The thousands nibble is left unadjusted: its +3 only feeds a
  // fifth digit that does not exist, and leaving it raw lets
  // overrange counts show up as a nibble >= 10.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bitcnt == LAST_BIT) state_nxt = ST_DONE;
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      scratch <= '0;
      bitcnt  <= '0;
      bcd     <= '0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            bitcnt  <= '0;
            busy    <= 1'b1;
          end
        end
        ST_SHIFT: begin
          scratch <= {adj[14:0], shreg[BIN_W-1]};
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          bitcnt  <= bitcnt + 1'b1;
        end
        ST_DONE: begin
          bcd  <= scratch;
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/car_count_display.sv
// Car count display: binary count -> BCD, then a 4-digit
// multiplexed common-anode 7-segment scan with dash overflow.
module car_count_display
  import car_count_display_pkg::*;
#(
  parameter int COUNT_W  = 14,
  parameter int MAX_DISP = 9999,
  parameter int SCAN_DIV = 50000,
  parameter int LZ_BLANK = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] count,
  output logic [6:0]         seg,
  output logic [3:0]         an,
  output logic [15:0]        bcd,
  output logic               busy,
  output logic               ovf
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(SCAN_DIV - 1);
  localparam logic [COUNT_W-1:0] MAX_V = COUNT_W'(MAX_DISP);

  logic [COUNT_W-1:0] last_conv;
  logic               start;
  logic               done;
  logic [PRE_W-1:0]   pre;
  logic [1:0]         idx;
  logic [3:0]         nib;
  logic               upper_zero;
  logic [6:0]         seg_nxt;
  logic [3:0]         an_nxt;

  // Only compare while idle so the newest count is taken once
  // the current run finishes; intermediate values may be skipped.
  assign start = !busy && (count != last_conv);

  bin2bcd_seq #(
    .BIN_W (COUNT_W)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (count),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_conv <= '0;
      ovf       <= 1'b0;
    end else begin
      if (start) last_conv <= count;
      if (done)  ovf <= (last_conv > MAX_V);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_TC) begin
      pre <= '0;
      idx <= idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_comb begin
    nib        = bcd[idx*4 +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i >= int'(idx) && bcd[i*4 +: 4] != 4'd0)
        upper_zero = 1'b0;
    end
  end

  always_comb begin
    an_nxt = ~(4'b0001 << idx);
    if (ovf)
      seg_nxt = SEG_DASH;
    else if (LZ_BLANK != 0 && idx != 2'd0 && upper_zero)
      seg_nxt = SEG_BLANK;
    else
      seg_nxt = seg_decode(nib);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_car_count_display.sv
// Directed bench for car_count_display with a fast scan rate.
// Inputs change and outputs are sampled on the falling edge.
module tb_car_count_display;

  logic        clk;
  logic        reset;
  logic [13:0] count;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        busy;
  logic        ovf;

  int checks;
  int failures;

  car_count_display #(
    .COUNT_W  (14),
    .MAX_DISP (9999),
    .SCAN_DIV (4),
    .LZ_BLANK (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .count (count),
    .seg   (seg),
    .an    (an),
    .bcd   (bcd),
    .busy  (busy),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  task automatic convert(input logic [13:0] v);
    count = v;
    @(negedge clk);
    wait_idle();
  endtask

  task automatic check_slot(input string tag, input logic [3:0] an_v,
                            input logic [6:0] seg_v);
    int n;
    @(negedge clk);
    n = 0;
    while (an !== an_v && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_an"}, {28'b0, an}, {28'b0, an_v});
    chk({tag, "_seg"}, {25'b0, seg}, {25'b0, seg_v});
  endtask

  initial begin
    int nbusy;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    count    = 14'd0;

    // 1: reset state, then no conversion for an unchanged zero
    repeat (3) @(negedge clk);
    chk("rst_seg", {25'b0, seg}, 32'h7F);
    chk("rst_an", {28'b0, an}, 32'hF);
    chk("rst_bcd", {16'b0, bcd}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);
    reset = 1'b0;
    nbusy = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    chk("idle_no_busy", nbusy, 0);

    // 2: 1234, latency and scan
    count = 14'd1234;
    nbusy = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
    end
    chk("busy_len", nbusy, 15);
    chk("bcd_not_yet", {16'b0, bcd}, 32'h0);
    @(negedge clk);
    chk("busy_drop", {31'b0, busy}, 32'h0);
    chk("bcd_1234", {16'b0, bcd}, 32'h1234);
    check_slot("s1234_0", 4'hE, 7'h19);
    check_slot("s1234_1", 4'hD, 7'h30);
    check_slot("s1234_2", 4'hB, 7'h24);
    check_slot("s1234_3", 4'h7, 7'h79);

    // 3: leading-zero blanking
    convert(14'd7);
    chk("bcd_7", {16'b0, bcd}, 32'h0007);
    check_slot("s7_0", 4'hE, 7'h78);
    check_slot("s7_1", 4'hD, 7'h7F);
    check_slot("s7_2", 4'hB, 7'h7F);
    check_slot("s7_3", 4'h7, 7'h7F);
    convert(14'd1000);
    chk("bcd_1000", {16'b0, bcd}, 32'h1000);
    check_slot("s1000_0", 4'hE, 7'h40);
    check_slot("s1000_1", 4'hD, 7'h40);
    check_slot("s1000_2", 4'hB, 7'h40);
    check_slot("s1000_3", 4'h7, 7'h79);

    // 4: overflow dashes, then largest legal value
    convert(14'd10000);
    chk("ovf_10000", {31'b0, ovf}, 32'h1);
    chk("thou_10000", {28'b0, bcd[15:12]}, 32'hA);
    check_slot("sovf_0", 4'hE, 7'h3F);
    check_slot("sovf_1", 4'hD, 7'h3F);
    check_slot("sovf_2", 4'hB, 7'h3F);
    check_slot("sovf_3", 4'h7, 7'h3F);
    convert(14'd9999);
    chk("ovf_9999", {31'b0, ovf}, 32'h0);
    chk("bcd_9999", {16'b0, bcd}, 32'h9999);

    // 5: change while busy is deferred to a second run
    count = 14'd12;
    repeat (3) @(negedge clk);
    count = 14'd9999;
    wait_idle();
    chk("bcd_12", {16'b0, bcd}, 32'h0012);
    @(negedge clk);
    chk("rerun_busy", {31'b0, busy}, 32'h1);
    wait_idle();
    chk("bcd_final", {16'b0, bcd}, 32'h9999);

    // 6: reset mid-conversion aborts, then restart
    count = 14'd5000;
    repeat (6) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_bcd", {16'b0, bcd}, 32'h0);
    chk("abort_an", {28'b0, an}, 32'hF);
    chk("abort_seg", {25'b0, seg}, 32'h7F);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("restart_busy", {31'b0, busy}, 32'h1);
    wait_idle();
    chk("bcd_5000", {16'b0, bcd}, 32'h5000);
    chk("ovf_5000", {31'b0, ovf}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
